frog_move_controller: RTL

Sequences the frog sprite position from the four debounced player switches. It converts switch presses into tile-sized hops, animated over several frames. It enforces playfield bounds and runs the life/death/win game state. Its outputs drive the X_Position/Y_Position inputs of Sprite_Display, replacing the fixed position registers in Frogger_Game.

---
 rtl/frog_move_controller.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/frog_move_controller.sv
// Frog sprite motion and game-state controller: turns switch presses into animated
// tile hops, enforces playfield bounds and runs the life / death / win / game-over flow.
module frog_move_controller #(
  parameter int TILE_SIZE    = 32,
  parameter int GRID_COLS    = 20,
  parameter int GRID_ROWS    = 15,
  parameter int START_COL    = 10,
  parameter int START_ROW    = 12,
  parameter int HOP_STEP     = 4,
  parameter int DEATH_FRAMES = 60,
  parameter int START_LIVES  = 3
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  input  logic       i_Frame_Tick,
  input  logic       i_Collision,
  output logic [9:0] o_X_Position,
  output logic [8:0] o_Y_Position,
  output logic [4:0] o_Col,
  output logic [3:0] o_Row,
  output logic       o_Hopping,
  output logic [1:0] o_Lives,
  output logic [7:0] o_Score,
  output logic       o_Win_Pulse,
  output logic       o_Death_Pulse,
  output logic       o_Game_Over
);

  localparam int HOP_TICKS = TILE_SIZE / HOP_STEP;
  localparam int HC_W      = $clog2(HOP_TICKS + 1);
  localparam int DC_W      = $clog2(DEATH_FRAMES + 1);
  localparam logic [9:0] X_START = 10'(START_COL * TILE_SIZE);
  localparam logic [8:0] Y_START = 9'(START_ROW * TILE_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_HOP, S_DEAD, S_WIN, S_GAME_OVER} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t            state;
  dir_t              dir;
  dir_t              press_dir;
  logic [3:0]        sw;
  logic [3:0]        sw_hist_p0;
  logic [3:0]        press;
  logic              press_any;
  logic              press_ok;
  logic [9:0]        x_pos;
  logic [8:0]        y_pos;
  logic [4:0]        col;
  logic [3:0]        row;
  logic [1:0]        lives;
  logic [7:0]        score;
  logic              win_pulse;
  logic              death_pulse;
  logic [HC_W-1:0]   hop_cnt;
  logic [DC_W-1:0]   death_cnt;

  function automatic logic [9:0] step_x(input logic [9:0] x, input dir_t d);
    case (d)
      DIR_LEFT:  step_x = x - 10'(HOP_STEP);
      DIR_RIGHT: step_x = x + 10'(HOP_STEP);
      default:   step_x = x;
    endcase
  endfunction

  function automatic logic [8:0] step_y(input logic [8:0] y, input dir_t d);
    case (d)
      DIR_UP:   step_y = y - 9'(HOP_STEP);
      DIR_DOWN: step_y = y + 9'(HOP_STEP);
      default:  step_y = y;
    endcase
  endfunction

  assign sw    = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
  assign press = sw & ~sw_hist_p0;

  // Highest-priority press wins; bounds are judged on the tile grid only.
  always_comb begin
    press_any = |press;
    press_dir = DIR_RIGHT;
    if (press[0])      press_dir = DIR_UP;
    else if (press[1]) press_dir = DIR_DOWN;
    else if (press[2]) press_dir = DIR_LEFT;
    case (press_dir)
      DIR_UP:   press_ok = (row != 4'd0);
      DIR_DOWN: press_ok = (row != 4'(GRID_ROWS - 1));
      DIR_LEFT: press_ok = (col != 5'd0);
      default:  press_ok = (col != 5'(GRID_COLS - 1));
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      dir         <= DIR_UP;
      sw_hist_p0  <= 4'b1111;
      x_pos       <= X_START;
      y_pos       <= Y_START;
      col         <= 5'(START_COL);
      row         <= 4'(START_ROW);
      lives       <= 2'(START_LIVES);
      score       <= 8'd0;
      win_pulse   <= 1'b0;
      death_pulse <= 1'b0;
      hop_cnt     <= '0;
      death_cnt   <= '0;
    end else begin
      sw_hist_p0  <= sw;
      win_pulse   <= 1'b0;
      death_pulse <= 1'b0;
      case (state)
        S_IDLE, S_HOP: begin
          if (i_Collision) begin
            state       <= S_DEAD;
            death_pulse <= 1'b1;
            death_cnt   <= '0;
            hop_cnt     <= '0;
            if (lives != 2'd0) lives <= lives - 2'd1;
          end else if (state == S_IDLE) begin
            if (press_any && press_ok) begin
              dir     <= press_dir;
              hop_cnt <= '0;
              state   <= S_HOP;
              case (press_dir)
                DIR_UP:   row <= row - 4'd1;
                DIR_DOWN: row <= row + 4'd1;
                DIR_LEFT: col <= col - 5'd1;
                default:  col <= col + 5'd1;
              endcase
            end
          end else if (i_Frame_Tick) begin
            x_pos <= step_x(x_pos, dir);
            y_pos <= step_y(y_pos, dir);
            if (hop_cnt == HC_W'(HOP_TICKS - 1)) begin
              hop_cnt <= '0;
              if (row == 4'd0) begin
                state     <= S_WIN;
                win_pulse <= 1'b1;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              hop_cnt <= hop_cnt + 1'b1;
            end
          end
        end
        S_DEAD: begin
          if (i_Frame_Tick) begin
            if (death_cnt == DC_W'(DEATH_FRAMES - 1)) begin
              death_cnt <= '0;
              x_pos     <= X_START;
              y_pos     <= Y_START;
              col       <= 5'(START_COL);
              row       <= 4'(START_ROW);
              state     <= (lives != 2'd0) ? S_IDLE : S_GAME_OVER;
            end else begin
              death_cnt <= death_cnt + 1'b1;
            end
          end
        end
        S_WIN: begin
          score <= score + 8'd1;
          x_pos <= X_START;
          y_pos <= Y_START;
          col   <= 5'(START_COL);
          row   <= 4'(START_ROW);
          state <= S_IDLE;
        end
        S_GAME_OVER: begin
          if (press_any) begin
            lives <= 2'(START_LIVES);
            score <= 8'd0;
            x_pos <= X_START;
            y_pos <= Y_START;
            col   <= 5'(START_COL);
            row   <= 4'(START_ROW);
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_X_Position  = x_pos;
  assign o_Y_Position  = y_pos;
  assign o_Col         = col;
  assign o_Row         = row;
  assign o_Hopping     = (state == S_HOP);
  assign o_Lives       = lives;
  assign o_Score       = score;
  assign o_Win_Pulse   = win_pulse;
  assign o_Death_Pulse = death_pulse;
  assign o_Game_Over   = (state == S_GAME_OVER);

endmodule
